// File: rtl/id_stage.sv
// Decode stage of the 5-stage MIPS pipeline: IF/ID register, register file,
// main control decode, sign extension and load-use hazard detection.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [6:0]  if_pc,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        pc_write,
    output logic [6:0]  PC,
    output logic [31:0] ReadReg1,
    output logic [31:0] ReadReg2,
    output logic [31:0] Offset,
    output logic [4:0]  Shamt,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [1:0]  WB,
    output logic [2:0]  MEM,
    output logic [4:0]  EX,
    output logic        bne
);

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [6:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic        reads_rt, stall;
    logic [1:0]  wb_c;
    logic [2:0]  mem_c;
    logic [4:0]  ex_c;
    logic        bne_c;
    logic [2:0]  alu_op;
    logic        r_valid;

    assign op    = ifid_instr_q[31:26];
    assign rs    = ifid_instr_q[25:21];
    assign rt    = ifid_instr_q[20:16];
    assign funct = ifid_instr_q[5:0];

    // Load-use hazard; a flush squashes the dependent instruction anyway
    always_comb begin
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        stall = ex_memread && (ex_rt != 5'd0) && !flush &&
                ((ex_rt == rs) || ((ex_rt == rt) && reads_rt));
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (flush) begin
            ifid_instr_d = '0;
            ifid_pc_d    = '0;
        end else if (!stall) begin
            ifid_instr_d = if_instr;
            ifid_pc_d    = if_pc;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_regwrite && (wb_rd != 5'd0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            regs_q       <= regs_d;
        end
    end

    // Register 0 is hardwired; same-cycle write-back is forwarded to the reader
    always_comb begin
        ReadReg1 = regs_q[rs];
        if (rs == 5'd0) begin
            ReadReg1 = '0;
        end else if (wb_regwrite && (wb_rd == rs)) begin
            ReadReg1 = wb_data;
        end
        ReadReg2 = regs_q[rt];
        if (rt == 5'd0) begin
            ReadReg2 = '0;
        end else if (wb_regwrite && (wb_rd == rt)) begin
            ReadReg2 = wb_data;
        end
    end

    always_comb begin
        wb_c    = 2'b00;
        mem_c   = 3'b000;
        ex_c    = 5'b00000;
        bne_c   = 1'b0;
        alu_op  = 3'b000;
        r_valid = 1'b0;
        case (op)
            6'h00: begin
                r_valid = (ifid_instr_q != 32'd0);
                case (funct)
                    6'h20:   alu_op = 3'b000;
                    6'h22:   alu_op = 3'b001;
                    6'h24:   alu_op = 3'b010;
                    6'h25:   alu_op = 3'b011;
                    6'h2A:   alu_op = 3'b100;
                    6'h00:   alu_op = 3'b101;
                    6'h02:   alu_op = 3'b110;
                    default: r_valid = 1'b0;
                endcase
                if (r_valid) begin
                    wb_c = 2'b10;
                    ex_c = {1'b1, alu_op, 1'b0};
                end
            end
            6'h23: begin
                wb_c  = 2'b11;
                mem_c = 3'b010;
                ex_c  = 5'b00001;
            end
            6'h2B: begin
                mem_c = 3'b001;
                ex_c  = 5'b00001;
            end
            6'h08: begin
                wb_c = 2'b10;
                ex_c = 5'b00001;
            end
            6'h04: begin
                mem_c = 3'b100;
                ex_c  = 5'b00010;
            end
            6'h05: begin
                mem_c = 3'b100;
                ex_c  = 5'b00010;
                bne_c = 1'b1;
            end
            default: ;
        endcase
    end

    // A stalled cycle sends a bubble to ID/EX while the data fields stay live
    always_comb begin
        pc_write = !stall;
        WB       = stall ? 2'b00 : wb_c;
        MEM      = stall ? 3'b000 : mem_c;
        EX       = stall ? 5'b00000 : ex_c;
        bne      = stall ? 1'b0 : bne_c;
        PC       = ifid_pc_q;
        Offset   = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
        Shamt    = ifid_instr_q[10:6];
        Rt       = rt;
        Rd       = ifid_instr_q[15:11];
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a reference model pushes expected outputs
// per cycle into a scoreboard queue, which a monitor pops on the falling edge.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr;
    logic [6:0]  if_pc;
    logic        flush;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_write;
    logic [6:0]  PC;
    logic [31:0] ReadReg1, ReadReg2, Offset;
    logic [4:0]  Shamt, Rt, Rd;
    logic [1:0]  WB;
    logic [2:0]  MEM;
    logic [4:0]  EX;
    logic        bne;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .pc_write(pc_write), .PC(PC),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .Offset(Offset), .Shamt(Shamt),
        .Rt(Rt), .Rd(Rd), .WB(WB), .MEM(MEM), .EX(EX), .bne(bne)
    );

    typedef struct {
        logic        pc_write;
        logic [6:0]  pc;
        logic [31:0] rr1, rr2, off;
        logic [4:0]  shamt, rt, rd;
        logic [10:0] ctrl;
    } exp_t;

    exp_t        sb_q[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] m_instr;
    logic [6:0]  m_pc;
    logic [31:0] m_regs [32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Controls packed as {WB[1:0], MEM[2:0], EX[4:0], bne}
    function automatic logic [10:0] refDecode(input logic [31:0] ins);
        logic [10:0] c;
        c = 11'd0;
        if (ins[31:26] == 6'h00 && ins != 32'd0) begin
            unique case (ins[5:0])
                6'h20: c = {2'b10, 3'b000, 5'b1_000_0, 1'b0};
                6'h22: c = {2'b10, 3'b000, 5'b1_001_0, 1'b0};
                6'h24: c = {2'b10, 3'b000, 5'b1_010_0, 1'b0};
                6'h25: c = {2'b10, 3'b000, 5'b1_011_0, 1'b0};
                6'h2A: c = {2'b10, 3'b000, 5'b1_100_0, 1'b0};
                6'h00: c = {2'b10, 3'b000, 5'b1_101_0, 1'b0};
                6'h02: c = {2'b10, 3'b000, 5'b1_110_0, 1'b0};
                default: c = 11'd0;
            endcase
        end else if (ins[31:26] == 6'h23) c = {2'b11, 3'b010, 5'b0_000_1, 1'b0};
        else if (ins[31:26] == 6'h2B) c = {2'b00, 3'b001, 5'b0_000_1, 1'b0};
        else if (ins[31:26] == 6'h08) c = {2'b10, 3'b000, 5'b0_000_1, 1'b0};
        else if (ins[31:26] == 6'h04) c = {2'b00, 3'b100, 5'b0_001_0, 1'b0};
        else if (ins[31:26] == 6'h05) c = {2'b00, 3'b100, 5'b0_001_0, 1'b1};
        return c;
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] a, input logic wr,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wr && wa == a) return wd;
        return m_regs[a];
    endfunction

    // Drive one cycle of inputs, push the model's expectation, advance the model
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic [6:0] pc,
                                 input logic fl, input logic mr, input logic [4:0] ert,
                                 input logic wr, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        logic usesRt, stl;
        @(posedge clk);
        #1;
        rst = r; if_instr = ins; if_pc = pc; flush = fl; ex_memread = mr;
        ex_rt = ert; wb_regwrite = wr; wb_rd = wa; wb_data = wd;
        usesRt = (m_instr[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05});
        stl = !fl && mr && ert != 5'd0 &&
              (ert == m_instr[25:21] || (usesRt && ert == m_instr[20:16]));
        e.pc_write = !stl;
        e.pc       = m_pc;
        e.rr1      = refRead(m_instr[25:21], wr, wa, wd);
        e.rr2      = refRead(m_instr[20:16], wr, wa, wd);
        e.off      = {{16{m_instr[15]}}, m_instr[15:0]};
        e.shamt    = m_instr[10:6];
        e.rt       = m_instr[20:16];
        e.rd       = m_instr[15:11];
        e.ctrl     = stl ? 11'd0 : refDecode(m_instr);
        sb_q.push_back(e);
        if (r) begin
            m_instr = 32'd0;
            m_pc    = 7'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (wr && wa != 5'd0) m_regs[wa] = wd;
            if (fl) begin
                m_instr = 32'd0;
                m_pc    = 7'd0;
            end else if (!stl) begin
                m_instr = ins;
                m_pc    = pc;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("pc_write", 32'(pc_write), 32'(e.pc_write));
            checkOutput("PC", 32'(PC), 32'(e.pc));
            checkOutput("ReadReg1", ReadReg1, e.rr1);
            checkOutput("ReadReg2", ReadReg2, e.rr2);
            checkOutput("Offset", Offset, e.off);
            checkOutput("Shamt", 32'(Shamt), 32'(e.shamt));
            checkOutput("Rt", 32'(Rt), 32'(e.rt));
            checkOutput("Rd", 32'(Rd), 32'(e.rd));
            checkOutput("ctrl", 32'({WB, MEM, EX, bne}), 32'(e.ctrl));
        end
    end

    localparam logic [31:0] ADD  = 32'h012A4020;
    localparam logic [31:0] LW   = 32'h8D280004;
    localparam logic [31:0] ADDI = 32'h2008FFFF;
    localparam logic [31:0] BNE  = 32'h15090003;

    initial begin
        logic [5:0]  ops [7];
        logic [5:0]  functs [8];
        logic [31:0] ins;
        ops    = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h3F};
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
        m_instr = 32'd0;
        m_pc    = 7'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst = 1'b1; if_instr = '0; if_pc = '0; flush = 1'b0; ex_memread = 1'b0;
        ex_rt = '0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);

        applyStimulus(0, 32'd0, 7'd0, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("reset_pc_write", 32'(pc_write), 32'd1);
        checkOutput("reset_ctrl", 32'({WB, MEM, EX, bne}), 32'd0);
        applyStimulus(0, 32'd0, 7'd0, 0, 0, 5'd0, 1, 5'd9, 32'd5);
        applyStimulus(0, ADD, 7'd1, 0, 0, 5'd0, 1, 5'd10, 32'd7);
        applyStimulus(0, LW, 7'd2, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("add_rr1", ReadReg1, 32'd5);
        checkOutput("add_rr2", ReadReg2, 32'd7);
        checkOutput("add_EX", 32'(EX), 32'b10000);
        applyStimulus(0, ADDI, 7'd3, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("lw_offset", Offset, 32'd4);
        checkOutput("lw_WB_MEM", 32'({WB, MEM}), 32'b11_010);
        applyStimulus(0, ADD, 7'd4, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("addi_offset", Offset, 32'hFFFFFFFF);
        applyStimulus(0, LW, 7'd5, 0, 1, 5'd9, 0, 5'd0, 32'd0);
        #2 checkOutput("stall_pc_write", 32'(pc_write), 32'd0);
        checkOutput("stall_EX", 32'(EX), 32'd0);
        applyStimulus(0, ADD, 7'd6, 0, 0, 5'd0, 1, 5'd9, 32'hDEADBEEF);
        #2 checkOutput("held_Rd", 32'(Rd), 32'd8);
        checkOutput("restored_EX", 32'(EX), 32'b10000);
        checkOutput("bypass_rr1", ReadReg1, 32'hDEADBEEF);
        applyStimulus(0, ADDI, 7'd7, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        applyStimulus(0, ADDI, 7'd8, 0, 0, 5'd0, 1, 5'd0, 32'h12345678);
        #2 checkOutput("r0_bypass", ReadReg1, 32'd0);
        applyStimulus(0, ADD, 7'd9, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("r0_stays", ReadReg1, 32'd0);
        applyStimulus(0, LW, 7'd10, 1, 1, 5'd9, 0, 5'd0, 32'd0);
        #2 checkOutput("flush_pc_write", 32'(pc_write), 32'd1);
        applyStimulus(0, BNE, 7'd11, 0, 1, 5'd9, 0, 5'd0, 32'd0);
        #2 checkOutput("flushed_PC", 32'(PC), 32'd0);
        checkOutput("flushed_ctrl", 32'({WB, MEM, EX, bne}), 32'd0);
        applyStimulus(0, ADD, 7'd12, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("bne_ctrl", 32'({MEM, EX, bne}), 32'b100_00010_1);
        checkOutput("bne_offset", Offset, 32'd3);
        applyStimulus(1, LW, 7'd13, 0, 1, 5'd10, 0, 5'd0, 32'd0);
        applyStimulus(0, ADD, 7'd14, 0, 1, 5'd10, 0, 5'd0, 32'd0);
        #2 checkOutput("rst_stall_pc_write", 32'(pc_write), 32'd1);
        applyStimulus(0, ADD, 7'd15, 0, 0, 5'd0, 0, 5'd0, 32'd0);
        #2 checkOutput("rst_cleared_reg", ReadReg1, 32'd0);

        for (int n = 0; n < 300; n++) begin
            ins = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom)};
            if (ins[31:26] == 6'h00) ins[5:0] = functs[$urandom_range(0, 7)];
            applyStimulus(($urandom_range(0, 39) == 0), ins, 7'($urandom),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          5'($urandom_range(0, 3)), $urandom);
        end
        @(posedge clk);
        @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
